send_engine: RTL and testbench

Memory-to-stream transfer engine that consumes the send-start command issued by the execute stage.
- On a start pulse it fetches a block of consecutive 32-bit words from memory through its own bus-master request port.
- Words are buffered in a small FIFO and emitted on a valid/ready output stream.
- It reports busy/done status and a transfer ID back to the core.

---
 rtl/send_engine.sv | 137 +++++++++++++
 tb/tb_send_engine.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/send_engine.sv
// send_engine: fetches a block of 32-bit words over a bus-master port and streams them out through a small FIFO.
// Build option SEND_ENGINE_CHKSUM_EN appends a 32-bit wrapping checksum trailer word to every transfer.
module send_engine #(
  parameter int unsigned MAX_WORDS  = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       send_start_i,
  input  logic [31:0]                base_addr_i,
  input  logic [$clog2(MAX_WORDS):0] word_cnt_i,
  output logic                       mem_req_o,
  output logic [31:0]                mem_addr_o,
  input  logic                       mem_gnt_i,
  input  logic [31:0]                mem_rdata_i,
  output logic [31:0]                tx_data_o,
  output logic                       tx_valid_o,
  input  logic                       tx_ready_i,
  output logic                       busy_o,
  output logic                       ready_o,
  output logic [31:0]                id_o
);

  localparam int unsigned CNT_W  = $clog2(MAX_WORDS) + 1;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned FCNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t             state_q, state_d;
  logic [31:0]        addr_q;
  logic [CNT_W-1:0]   remain_q;
  logic [31:0]        id_q;
  logic [31:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [FCNT_W-1:0]  fcnt_q;
  logic               fifo_full, fifo_empty;
  logic               push, pop, start_acc, xfer_end;

  assign fifo_full  = (fcnt_q == FCNT_W'(FIFO_DEPTH));
  assign fifo_empty = (fcnt_q == '0);
  assign start_acc  = (state_q == IDLE) && send_start_i;

  // Request only when there is guaranteed room; a same-cycle pop does not count.
  assign mem_req_o  = (state_q == XFER) && (remain_q != '0) && !fifo_full;
  assign mem_addr_o = addr_q;
  assign push       = mem_req_o && mem_gnt_i;
  assign pop        = !fifo_empty && tx_ready_i;

  assign busy_o  = (state_q == XFER);
  assign ready_o = (state_q == DONE);
  assign id_o    = id_q;

`ifdef SEND_ENGINE_CHKSUM_EN
  logic [31:0] sum_q;
  logic        trailer_valid;

  // Trailer is offered once every data word has been fetched and drained.
  assign trailer_valid = (state_q == XFER) && (remain_q == '0) && fifo_empty;
  assign tx_valid_o    = !fifo_empty || trailer_valid;
  assign tx_data_o     = !fifo_empty ? fifo_mem[rd_ptr_q] : (trailer_valid ? sum_q : 32'd0);
  assign xfer_end      = trailer_valid && tx_ready_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_q <= 32'd0;
    end else if (start_acc) begin
      sum_q <= 32'd0;
    end else if (pop) begin
      sum_q <= sum_q + fifo_mem[rd_ptr_q];
    end
  end
`else
  assign tx_valid_o = !fifo_empty;
  assign tx_data_o  = fifo_empty ? 32'd0 : fifo_mem[rd_ptr_q];
  assign xfer_end   = (state_q == XFER) && (remain_q == '0) && fifo_empty && !push;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (send_start_i) state_d = XFER;
      XFER:    if (xfer_end) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Transfer bookkeeping: word-aligned address, clamped word budget, completion counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q   <= 32'd0;
      remain_q <= '0;
      id_q     <= 32'd0;
    end else begin
      if (start_acc) begin
        addr_q   <= {base_addr_i[31:2], 2'b00};
        remain_q <= (word_cnt_i > CNT_W'(MAX_WORDS)) ? CNT_W'(MAX_WORDS) : word_cnt_i;
      end else if (push) begin
        addr_q   <= addr_q + 32'd4;
        remain_q <= remain_q - CNT_W'(1);
      end
      if (state_q == DONE) begin
        id_q <= id_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fcnt_q   <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   fcnt_q <= fcnt_q + FCNT_W'(1);
        2'b01:   fcnt_q <= fcnt_q - FCNT_W'(1);
        default: fcnt_q <= fcnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= mem_rdata_i;
  end

endmodule

// File: tb/tb_send_engine.sv
// Directed scoreboard bench for send_engine; expected addresses and stream words are queued at start.
module tb_send_engine;

  localparam int unsigned MAX_WORDS  = 16;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned CNT_W      = $clog2(MAX_WORDS) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             send_start_i = 1'b0;
  logic [31:0]      base_addr_i = 32'd0;
  logic [CNT_W-1:0] word_cnt_i = '0;
  logic             mem_req_o;
  logic [31:0]      mem_addr_o;
  logic             mem_gnt_i = 1'b0;
  logic [31:0]      mem_rdata_i;
  logic [31:0]      tx_data_o;
  logic             tx_valid_o;
  logic             tx_ready_i = 1'b0;
  logic             busy_o;
  logic             ready_o;
  logic [31:0]      id_o;

  int          checks = 0;
  int          errors = 0;
  int          gnt_cnt = 0;
  int          ready_cnt = 0;
  logic        req_seen = 1'b0;
  logic [31:0] exp_addr [$];
  logic [31:0] exp_data [$];

  send_engine #(.MAX_WORDS(MAX_WORDS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst), .send_start_i(send_start_i), .base_addr_i(base_addr_i),
    .word_cnt_i(word_cnt_i), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_gnt_i(mem_gnt_i), .mem_rdata_i(mem_rdata_i), .tx_data_o(tx_data_o),
    .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i), .busy_o(busy_o),
    .ready_o(ready_o), .id_o(id_o)
  );

  always #5 clk = ~clk;

  // Memory image: 0x1000 -> 0xA, 0x1004 -> 0xB, ...; two fixed words at 0x8000 for the checksum case.
  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (a == 32'h0000_8000) return 32'hFFFF_FFFF;
    if (a == 32'h0000_8004) return 32'h0000_0002;
    return (a >> 2) - 32'h0000_03F6;
  endfunction

  assign mem_rdata_i = mem_data(mem_addr_o);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Monitor samples at negedge the handshakes that complete on the following posedge.
  always @(negedge clk) begin
    if (rst) begin
      if (mem_req_o) req_seen = 1'b1;
      if (mem_req_o && mem_gnt_i) begin
        gnt_cnt++;
        if (exp_addr.size() == 0) chk("extra_read", 32'(exp_addr.size()), 32'd1);
        else chk("mem_addr", mem_addr_o, exp_addr.pop_front());
      end
      if (tx_valid_o && tx_ready_i) begin
        if (exp_data.size() == 0) chk("extra_word", 32'(exp_data.size()), 32'd1);
        else chk("tx_data", tx_data_o, exp_data.pop_front());
      end
      if (ready_o) begin
        ready_cnt++;
        chk("done_words_left", 32'(exp_data.size()), 32'd0);
        chk("done_reads_left", 32'(exp_addr.size()), 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [31:0] base, input int cnt);
    int n;
    logic [31:0] a;
`ifdef SEND_ENGINE_CHKSUM_EN
    logic [31:0] s;
    s = 32'd0;
`endif
    n = (cnt > int'(MAX_WORDS)) ? int'(MAX_WORDS) : cnt;
    a = {base[31:2], 2'b00};
    for (int i = 0; i < n; i++) begin
      exp_addr.push_back(a);
      exp_data.push_back(mem_data(a));
`ifdef SEND_ENGINE_CHKSUM_EN
      s = s + mem_data(a);
`endif
      a = a + 32'd4;
    end
`ifdef SEND_ENGINE_CHKSUM_EN
    exp_data.push_back(s);
`endif
    gnt_cnt = 0;
    ready_cnt = 0;
    req_seen = 1'b0;
    base_addr_i = base;
    word_cnt_i = CNT_W'(cnt);
    send_start_i = 1'b1;
    tick();
    send_start_i = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max_cycles);
    int i;
    i = 0;
    while (ready_o !== 1'b1 && i < max_cycles) begin
      @(negedge clk);
      i++;
    end
    chk({tag, "_ready"}, 32'(ready_o), 32'd1);
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_mem_req"}, 32'(mem_req_o), 32'd0);
    chk({tag, "_mem_addr"}, mem_addr_o, 32'd0);
    chk({tag, "_tx_valid"}, 32'(tx_valid_o), 32'd0);
    chk({tag, "_tx_data"}, tx_data_o, 32'd0);
    chk({tag, "_busy"}, 32'(busy_o), 32'd0);
    chk({tag, "_ready"}, 32'(ready_o), 32'd0);
    chk({tag, "_id"}, id_o, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    check_reset_outputs("rst");
    rst = 1'b1;
    tick();

    // Basic transfer at full throughput.
    mem_gnt_i = 1'b1;
    tx_ready_i = 1'b1;
    start(32'h0000_1000, 3);
    chk("t1_busy", 32'(busy_o), 32'd1);
    wait_done("t1", 40);
    chk("t1_id", id_o, 32'd1);
    chk("t1_busy_after", 32'(busy_o), 32'd0);
    chk("t1_grants", 32'(gnt_cnt), 32'd3);
    chk("t1_ready_pulses", 32'(ready_cnt), 32'd1);

    // Unaligned base is rounded down to a word boundary.
    start(32'h0000_2003, 2);
    wait_done("t2", 40);
    chk("t2_grants", 32'(gnt_cnt), 32'd2);
    chk("t2_id", id_o, 32'd2);

    // Sink stalls: fetch stops once the FIFO fills and the head word holds.
    tx_ready_i = 1'b0;
    start(32'h0000_3000, 8);
    repeat (3) tick();
    chk("t3_head_early", tx_data_o, mem_data(32'h0000_3000));
    repeat (6) tick();
    chk("t3_grants_full", 32'(gnt_cnt), 32'(FIFO_DEPTH));
    chk("t3_req_blocked", 32'(mem_req_o), 32'd0);
    chk("t3_valid", 32'(tx_valid_o), 32'd1);
    chk("t3_head_late", tx_data_o, mem_data(32'h0000_3000));
    tx_ready_i = 1'b1;
    wait_done("t3", 60);
    chk("t3_grants", 32'(gnt_cnt), 32'd8);
    chk("t3_id", id_o, 32'd3);

    // Zero-length transfer: DONE two cycles after the start pulse.
    start(32'h0000_7000, 0);
    chk("t4_not_done_yet", 32'(ready_o), 32'd0);
    tick();
    chk("t4_done_at_2", 32'(ready_o), 32'd1);
    tick();
    chk("t4_id", id_o, 32'd4);
    chk("t4_no_req", 32'(req_seen), 32'd0);
    chk("t4_ready_pulses", 32'(ready_cnt), 32'd1);

    // Oversized request is clamped.
    start(32'h0000_4000, 20);
    wait_done("t5", 80);
    chk("t5_grants", 32'(gnt_cnt), 32'(MAX_WORDS));
    chk("t5_id", id_o, 32'd5);

    // Start while busy is ignored.
    start(32'h0000_5000, 4);
    tick();
    base_addr_i = 32'h0000_6000;
    word_cnt_i = CNT_W'(9);
    send_start_i = 1'b1;
    tick();
    send_start_i = 1'b0;
    wait_done("t6", 40);
    repeat (6) tick();
    chk("t6_grants", 32'(gnt_cnt), 32'd4);
    chk("t6_ready_pulses", 32'(ready_cnt), 32'd1);
    chk("t6_busy", 32'(busy_o), 32'd0);
    chk("t6_id", id_o, 32'd6);

`ifdef SEND_ENGINE_CHKSUM_EN
    // Checksum trailer: 0xFFFFFFFF + 0x2 wraps to 0x1.
    start(32'h0000_8000, 2);
    wait_done("t8", 40);
    chk("t8_grants", 32'(gnt_cnt), 32'd2);
    chk("t8_id", id_o, 32'd7);
`endif

    // Reset mid-transfer aborts immediately.
    tx_ready_i = 1'b0;
    start(32'h0000_3000, 8);
    repeat (3) tick();
    rst = 1'b0;
    #1;
    check_reset_outputs("t7_abort");
    exp_addr.delete();
    exp_data.delete();
    tick();
    rst = 1'b1;
    tx_ready_i = 1'b1;
    tick();
    chk("t7_id_after_rst", id_o, 32'd0);
    start(32'h0000_1000, 1);
    wait_done("t7_restart", 40);
    chk("t7_restart_id", id_o, 32'd1);
    chk("t7_restart_grants", 32'(gnt_cnt), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
